// File: rtl/enc_dec_pkg.sv
// Shared constants, frame field offsets and key mask for the function-1 codec.
// Field offsets use frame index 0 = MSB.
package enc_dec_pkg;

  localparam int FRAME_W = 78;
  localparam int PT_W    = 60;
  localparam int KEY_W   = 11;
  localparam int SUM_W   = 61;

  localparam logic [5:0] HDR_F1 = 6'b000001;

  localparam int HDR_FIRST = 0;
  localparam int HDR_LAST  = 5;
  localparam int KEY_FIRST = 6;
  localparam int KEY_LAST  = 16;
  localparam int SUM_FIRST = 17;
  localparam int SUM_LAST  = 77;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_HOLD
  } enc_state_e;

  // Mask segments, MSB first: r, ~r, ~r, r, ~r, top five bits of r.
  function automatic logic [PT_W-1:0] mask_f1(
    input logic [KEY_W-1:0] r
  );
    return {r, ~r, ~r, r, ~r, r[10:6]};
  endfunction

endpackage

// File: rtl/encrypt_function_1_lfsr11.sv
// Seedable 11-bit maximal-length LFSR supplying the per-word random key.
// A zero seed is replaced by 1 so the register can never lock up.
module lfsr11 #(
  parameter logic [10:0] RST_VAL = 11'h001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [10:0] seed,
  input  logic        adv,
  output logic [10:0] value
);

  logic [10:0] lfsr_q;
  logic [10:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 11'h000) ? 11'h001 : seed;
    end else if (adv) begin
      lfsr_d = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RST_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/encrypt_function_1.sv
// Function-1 encryptor: plaintext plus LFSR-derived mask, framed with
// header and key, behind valid/ready handshakes on both sides.
module encrypt_function_1
  import enc_dec_pkg::*;
#(
  parameter logic [5:0]  HDR      = HDR_F1,
  parameter logic [10:0] LFSR_RST = 11'h001
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        seed_load,
  input  logic [10:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [77:0] out_data
);

  enc_state_e         state_q, state_d;
  logic [PT_W-1:0]    p_q, p_d;
  logic [KEY_W-1:0]   r_q, r_d;
  logic               out_valid_q, out_valid_d;
  logic [FRAME_W-1:0] out_data_q, out_data_d;
  logic [FRAME_W-1:0] frame;
  logic [SUM_W-1:0]   sum;
  logic [KEY_W-1:0]   key;
  logic               accept;

  lfsr11 #(
    .RST_VAL(LFSR_RST)
  ) u_lfsr (
    .clk  (Clk),
    .rst_n(Rst_n),
    .load (seed_load),
    .seed (seed),
    .adv  (accept),
    .value(key)
  );

  assign in_ready = (state_q == S_IDLE)
                 || (state_q == S_HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  // Both operands are 60 bits, so the 61-bit sum cannot overflow.
  assign sum = {1'b0, p_q} + {1'b0, mask_f1(r_q)};

  always_comb begin
    frame = '0;
    frame[FRAME_W-1-HDR_FIRST -: HDR_LAST-HDR_FIRST+1] = HDR;
    frame[FRAME_W-1-KEY_FIRST -: KEY_LAST-KEY_FIRST+1] = r_q;
    frame[FRAME_W-1-SUM_FIRST -: SUM_LAST-SUM_FIRST+1] = sum;
  end

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    r_d         = r_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          p_d     = in_data;
          r_d     = key;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        out_data_d  = frame;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            p_d     = in_data;
            r_d     = key;
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_encrypt_function_1.sv
// Bench for encrypt_function_1: transaction scoreboard with a frame model
// and decryptor, plus directed vectors with literal expectations.
module tb_encrypt_function_1;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [10:0] seed = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [77:0] out_data;

  encrypt_function_1 dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .seed_load(seed_load),
    .seed     (seed),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mask from its ascending description: bit i (0 = MSB) is r[i mod 11],
  // inverted in the 2nd, 3rd and 5th eleven-bit segments.
  function automatic logic [59:0] m_mask(input logic [10:0] k);
    logic [59:0] b;
    logic        inv;
    int          j;
    int          seg;
    b = '0;
    for (int i = 0; i < 60; i++) begin
      j   = i % 11;
      seg = i / 11;
      inv = (seg == 1) || (seg == 2) || (seg == 4);
      b = b | (60'(((k >> (10 - j)) & 11'h1) ^ {10'b0, inv}) << (59 - i));
    end
    return b;
  endfunction

  function automatic logic [10:0] m_next(input logic [10:0] k);
    return {k[9:0], k[10] ^ k[8]};
  endfunction

  function automatic logic [77:0] m_frame(input logic [59:0] p,
                                          input logic [10:0] k);
    logic [60:0] y;
    y = {1'b0, p} + {1'b0, m_mask(k)};
    return {6'b000001, k, y};
  endfunction

  function automatic logic [59:0] m_decrypt(input logic [77:0] f);
    logic [60:0] d;
    d = f[60:0] - {1'b0, m_mask(f[71:61])};
    return d[59:0];
  endfunction

  typedef struct packed {
    logic [59:0] p;
    logic [10:0] k;
  } txn_t;

  txn_t        q[$];
  logic [10:0] mkey = 11'h001;
  int          hs_cnt = 0;
  bit          stall = 1'b0;
  logic [77:0] stall_data = '0;
  bit          loop_on = 1'b0;
  bit          seen[2048];

  // Inputs change just after posedge, so negedge values are what the
  // next rising edge will act on.
  initial begin
    txn_t t;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        q.delete();
        mkey  = 11'h001;
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", 128'(out_valid), 128'(1'b1));
          chk("hold_data", 128'(out_data), 128'(stall_data));
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_frame: got %h expected none",
                     out_data);
          end else begin
            t = q.pop_front();
            chk("frame", 128'(out_data), 128'(m_frame(t.p, t.k)));
            chk("decrypt", 128'(m_decrypt(out_data)), 128'(t.p));
            if (loop_on) seen[out_data[71:61]] = 1'b1;
          end
        end
        stall      = out_valid && !out_ready;
        stall_data = out_data;
        if (in_valid && in_ready) q.push_back('{p: in_data, k: mkey});
        if (seed_load) mkey = (seed == 11'h000) ? 11'h001 : seed;
        else if (in_valid && in_ready) mkey = m_next(mkey);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_word(input logic [59:0] p, output logic [77:0] f);
    int i;
    in_valid = 1'b1;
    in_data  = p;
    i = 0;
    @(negedge Clk);
    while (!in_ready && i < 50) begin
      @(negedge Clk);
      i++;
    end
    chk("accept_wait", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid  = 1'b0;
    seed_load = 1'b0;
    i = 0;
    @(negedge Clk);
    while (!out_valid && i < 50) begin
      @(negedge Clk);
      i++;
    end
    chk("frame_wait", 128'(out_valid), 128'(1'b1));
    f = out_data;
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [77:0] f;
    logic [77:0] mf;
    logic [10:0] pk;
    int          h0;
    int          n;
    int          cyc;
    int          cnt;
    bit          acc;

    mf = m_frame(60'h0, 11'h7FF);
    chk("model_f0", 128'(mf),
        128'({6'b000001, 11'h7FF, 61'h0FFE000007FF001F}));
    mf = m_frame({60{1'b1}}, 11'h7FF);
    chk("model_ones", 128'(mf[60:0]), 128'(61'h1FFE000007FF001E));

    repeat (3) @(negedge Clk);
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_out_data", 128'(out_data), 128'(78'h0));
    tick();
    Rst_n = 1'b1;
    tick();

    seed_load = 1'b1;
    seed      = 11'h7FF;
    tick();
    seed_load = 1'b0;
    do_word(60'h0, f);
    chk("f0", 128'(f),
        128'({6'b000001, 11'h7FF, 61'h0FFE000007FF001F}));
    do_word({60{1'b1}}, f);
    chk("f1_key", 128'(f[71:61]), 128'(11'h7FE));
    chk("f1_sum", 128'(f[60:0]), 128'(61'h1FFC00400FFE003E));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 60'h123456789ABCDEF;
    @(negedge Clk);
    chk("bp_idle_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_data = 60'h0F0F0F0F0F0F0F0;
    tick();
    h0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_in_ready", 128'(in_ready), 128'(1'b0));
      chk("bp_valid", 128'(out_valid), 128'(1'b1));
      tick();
    end
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_release_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("bp_one_frame", 128'(hs_cnt), 128'(h0 + 1));
    repeat (3) tick();
    chk("bp_second_frame", 128'(hs_cnt), 128'(h0 + 2));

    pk        = mkey;
    seed_load = 1'b1;
    seed      = 11'h000;
    do_word(60'hABC, f);
    chk("sl_old_key", 128'(f[71:61]), 128'(pk));
    do_word(60'h5, f);
    chk("sl_new_key", 128'(f[71:61]), 128'(11'h001));

    in_valid = 1'b1;
    in_data  = 60'hDEAD;
    @(negedge Clk);
    chk("rc_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    h0 = hs_cnt;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rc_valid", 128'(out_valid), 128'(1'b0));
    chk("rc_in_ready", 128'(in_ready), 128'(1'b1));
    repeat (2) @(negedge Clk);
    tick();
    Rst_n = 1'b1;
    repeat (3) tick();
    chk("rc_no_frame", 128'(hs_cnt), 128'(h0));
    do_word(60'h77, f);
    chk("rc_key", 128'(f[71:61]), 128'(11'h001));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 60'h1;
    tick();
    in_valid = 1'b0;
    tick();
    @(negedge Clk);
    chk("rh_pre_valid", 128'(out_valid), 128'(1'b1));
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("rh_valid", 128'(out_valid), 128'(1'b0));
    chk("rh_data", 128'(out_data), 128'(78'h0));
    @(negedge Clk);
    tick();
    Rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    seed_load = 1'b1;
    seed      = 11'h2A5;
    tick();
    seed_load = 1'b0;
    loop_on   = 1'b1;
    n   = 0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = 60'({$urandom(), $urandom()});
    while (n < 2047 && cyc < 30000) begin
      @(negedge Clk);
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        n++;
        in_data = 60'({$urandom(), $urandom()});
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("lb_drained", 128'(q.size()), 128'(0));
    loop_on = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2048; i++) cnt += int'(seen[i]);
    chk("lb_words", 128'(n), 128'(2047));
    chk("lb_distinct_keys", 128'(cnt), 128'(2047));
    chk("lb_zero_key", 128'(seen[0]), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
